rv32_branch_ctrl: RTL

//   Sequences control-flow redirects produced by the EX-stage branch unit. Captures a taken

---
 rtl/rv32_branch_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/rv32_branch_ctrl.sv
// Redirect sequencer between the EX-stage branch unit and fetch: captures taken targets,
// holds the fetch redirect until accepted, stalls EX and flushes wrong-path work.
module rv32_branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid_in,
    input  logic                 ex_taken_in,
    input  logic [31:0]          ex_target_in,
    output logic                 ex_ready_out,
    output logic                 redirect_valid_out,
    output logic [31:0]          redirect_pc_out,
    input  logic                 fetch_ready_in,
    output logic                 flush_out,
    output logic                 misaligned_out,
    output logic [CNT_WIDTH-1:0] taken_count_out
);

    typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

    // Wraps harmlessly when FLUSH_CYCLES is 0; that load path is never taken then.
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e               state_q, state_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic                 flush_q, flush_d;
    logic                 misaligned_q, misaligned_d;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

    logic ex_taken;
    assign ex_taken = ex_valid_in & ex_taken_in;

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        misaligned_d     = 1'b0;
        taken_count_d    = taken_count_q;

        unique case (state_q)
            StIdle: begin
                if (ex_taken && !ex_target_in[1]) begin
                    redirect_pc_d    = ex_target_in;
                    redirect_valid_d = 1'b1;
                    flush_d          = 1'b1;
                    state_d          = StReq;
                end else if (ex_taken) begin
                    misaligned_d = 1'b1;
                end
            end
            StReq: begin
                if (fetch_ready_in) begin
                    taken_count_d    = taken_count_q + CNT_WIDTH'(1);
                    redirect_valid_d = 1'b0;
                    if (FLUSH_CYCLES == 0) begin
                        flush_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        flush_cnt_d = FlushLoad;
                        state_d     = StFlush;
                    end
                end
            end
            StFlush: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                state_d          = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            misaligned_q     <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            misaligned_q     <= misaligned_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign ex_ready_out       = (state_q == StIdle);
    assign redirect_valid_out = redirect_valid_q;
    assign redirect_pc_out    = redirect_pc_q;
    assign flush_out          = flush_q;
    assign misaligned_out     = misaligned_q;
    assign taken_count_out    = taken_count_q;

endmodule
